avk_period_meter: RTL and testbench
===================================

Name: avk_period_meter

Overview:
- Reader end of the `reference` line driven by `avk_capacitance`. That line is a charge/discharge square wave whose period tracks the measured capacitance.
- Synchronises `reference` and counts 4 MHz clock cycles per full period and per high phase.
- Accumulates both counts over 2^AVG_LOG2 consecutive periods.
- Hands each averaged result to the host/readout logic through a valid/ready handshake. Flags timeouts (stuck line) and overruns.

Parameters:
- CNT_W, 24: width of the per-period cycle counters.
- AVG_LOG2, 2: log2 of the number of periods accumulated per result.
- TIMEOUT, 12_000_000: maximum cycles between rising edges (3 s at 4 MHz). Must be < 2^CNT_W.

Ports:
- clock  in  1  4 MHz system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  measurement enable; low forces IDLE
- reference  in  1  square wave from avk_capacitance; may be asynchronous
- result_ready  in  1  consumer accepts result this cycle
- result_valid  out  1  result registers hold an unaccepted result
- period_sum  out  CNT_W+AVG_LOG2  sum of period lengths in clocks
- high_sum  out  CNT_W+AVG_LOG2  sum of high-phase lengths in clocks
- overrun  out  1  an unaccepted result was overwritten since the last accept
- timeout  out  1  one-cycle pulse: no rising edge within TIMEOUT cycles
- busy  out  1  state is ARM or MEASURE

Behaviour:

Clock and reset:
- Single clock. Reset is synchronous and active-high.
- Reset drives all outputs, counters, accumulators, the sync chain and the state register to 0/IDLE.

Edge detection:
- `reference` passes through 2 flops to give ref_s; ref_d is ref_s delayed one cycle.
- rise = ref_s & ~ref_d.
- A change on `reference` therefore yields `rise` 3 clock edges later. The latency is constant, so counts are exact differences between edges.

State machine (IDLE, ARM, MEASURE):
- IDLE: counters and accumulators at 0. When enable=1, go to ARM.
- ARM: wait for `rise`. On rise: per_cnt<=1, hi_cnt<=1, n<=0, go to MEASURE.
- MEASURE, every cycle without rise: per_cnt+=1; hi_cnt+=1 if ref_s=1.
- MEASURE, on rise:
  - per_acc += per_cnt; hi_acc += hi_cnt; n += 1.
  - per_cnt<=1 and hi_cnt<=1; the same edge starts the next period, so there is no gap between periods.
- Completion: on the rise where n reaches 2^AVG_LOG2 (n wraps to 0):
  - period_sum and high_sum are loaded with the accumulated values including this period.
  - Accumulators are cleared and result_valid is set on the next cycle.
  - Measurement continues in MEASURE.
- Period definition: the number of clock edges between consecutive rising edges. A 1000-cycle wave counts 1000.

Timeout:
- Applies in ARM or MEASURE, using a separate wait counter that restarts at each rise and on entry to ARM.
- When the wait counter reaches TIMEOUT without a rise, `timeout` pulses for 1 cycle.
- Partial accumulators are discarded and the state returns to ARM.
- result registers and result_valid are untouched.

enable deasserted mid-operation:
- Go to IDLE next cycle and discard partial data.
- A pending result stays valid until accepted.

Handshake:
- result_valid holds until result_valid & result_ready, then clears next cycle unless a new result loads in that same cycle.
- Outputs are stable while valid and not accepted, except when overwritten.
- New result while valid=1 and ready=0: overwrite, set overrun.
- New result in the same cycle as an accept: load, valid stays 1, overrun unchanged.
- overrun clears on the accept of a result not itself overwritten, i.e. on any accept cycle with no simultaneous load.

Arithmetic:
- Accumulator width is CNT_W+AVG_LOG2, so it cannot overflow given the TIMEOUT bound. per_cnt cannot saturate.
- high_sum <= period_sum always.

Decomposition:
- Package avk_pkg holds:
  - CLK_HZ = 4_000_000
  - default TIMEOUT
  - the state enum type avk_meter_state_t {IDLE, ARM, MEASURE}
- One natural sub-module, avk_edge_sync: 2-flop synchroniser plus the ref_d register and rise/fall outputs, with synchronous reset. It is reused for the comparator inputs elsewhere.

Test Plan:
- Reset/enable: assert reset 10 cycles with reference toggling -> all outputs 0. Hold enable=0 for 5000 cycles -> busy=0, result_valid never 1.
- Steady wave: reference period 1000 clocks, high 400, enable=1, ready=1 -> first result_valid about 4000 cycles after the first synced rise, with period_sum=4000, high_sum=1600. Subsequent results every 4000 cycles, identical values, no gap.
- Timeout: TIMEOUT=5000, reference held 0 after one rise -> timeout pulses once at 5000 cycles, busy stays 1 (ARM). Result registers keep their previous values.
- Overrun/handshake: ready=0 across two completed results -> overrun=1, outputs show the second result. Pulse ready 1 cycle -> valid=0, overrun=0 next cycle. Accept coincident with a new load -> valid stays 1, overrun stays 0.
- Mid-operation abort: deassert enable after 2 of 4 periods, reassert -> no result until 4 fresh periods complete. Sums are exact, with no stale partial counts.
- Synchronous reset during MEASURE with result_valid=1 -> state IDLE, result_valid=0, sums 0 on the next cycle.

Source files
------------

// File: rtl/avk_pkg.sv
// avk_pkg: shared constants and types for the avk period meter slice.
//   CLK_HZ           system clock rate the meter counts in
//   TIMEOUT_DEFAULT  longest legal gap between rising edges (3 s)
//   avk_meter_state_t  meter FSM states
package avk_pkg;

  localparam int CLK_HZ          = 4_000_000;
  localparam int TIMEOUT_DEFAULT = 3 * CLK_HZ;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } avk_meter_state_t;

endpackage

// File: rtl/avk_period_meter_if.sv
// avk_period_meter_if: result handshake between the period meter and its
// consumer.
//   result_valid  result registers hold an unaccepted result
//   result_ready  consumer accepts the result this cycle
//   period_sum    summed period lengths (clocks)
//   high_sum      summed high-phase lengths (clocks)
//   overrun       an unaccepted result was overwritten since the last accept
// master = meter side, slave = consumer side.
interface avk_period_meter_if #(
  parameter int W = 26
) ();

  logic         result_valid;
  logic         result_ready;
  logic [W-1:0] period_sum;
  logic [W-1:0] high_sum;
  logic         overrun;

  modport master (
    output result_valid, period_sum, high_sum, overrun,
    input  result_ready
  );

  modport slave (
    input  result_valid, period_sum, high_sum, overrun,
    output result_ready
  );

endinterface

// File: rtl/avk_edge_sync.sv
// avk_edge_sync: 2-flop synchroniser for an asynchronous level plus a
// one-cycle-delayed copy for edge detection.
//   clock, reset  system clock, synchronous active-high reset
//   d             asynchronous input
//   q             synchronised level
//   rise, fall    single-cycle edge strobes derived from q
// A change on d shows up on rise/fall after two edges and is acted on by
// the third, a fixed latency so downstream edge-to-edge counts are exact.
module avk_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;
  logic       q_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync <= '0;
      q_d  <= 1'b0;
    end else begin
      sync <= {sync[0], d};
      q_d  <= sync[1];
    end
  end

  assign q    = sync[1];
  assign rise = sync[1] & ~q_d;
  assign fall = ~sync[1] & q_d;

endmodule

// File: rtl/avk_period_meter.sv
// avk_period_meter: measures the reference square wave from avk_capacitance.
// Counts clocks per full period and per high phase, sums 2^AVG_LOG2
// back-to-back periods and presents each sum over a valid/ready handshake.
//   clock, reset  system clock, synchronous active-high reset
//   enable        measurement enable; low forces IDLE
//   reference     asynchronous square wave
//   timeout       one-cycle pulse when no rising edge arrives within TIMEOUT
//   busy          FSM is in ARM or MEASURE
//   res           result handshake (period_sum, high_sum, overrun, ...)
module avk_period_meter
  import avk_pkg::*;
#(
  parameter int CNT_W    = 24,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                reference,
  output logic                timeout,
  output logic                busy,
  avk_period_meter_if.master  res
);

  localparam int SUM_W = CNT_W + AVG_LOG2;
  localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]    TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [AVG_LOG2-1:0] AVG_ONE = AVG_LOG2'(1);
  localparam logic [AVG_LOG2-1:0] N_LAST  = '1;

  avk_meter_state_t state, state_n;

  logic                ref_s, rise, fall_unused;
  logic [CNT_W-1:0]    per_cnt, hi_cnt, wait_cnt;
  logic [SUM_W-1:0]    per_acc, hi_acc, per_new, hi_new;
  logic [AVG_LOG2-1:0] n;
  logic                active, to_hit, done, accept;

  avk_edge_sync u_sync (
    .clock (clock),
    .reset (reset),
    .d     (reference),
    .q     (ref_s),
    .rise  (rise),
    .fall  (fall_unused)
  );

  assign active  = (state == ARM) || (state == MEASURE);
  // A rise restarts the wait counter, so it can never coincide with a timeout.
  assign to_hit  = enable & active & ~rise & (wait_cnt == TO_LAST);
  assign per_new = per_acc + SUM_W'(per_cnt);
  assign hi_new  = hi_acc + SUM_W'(hi_cnt);
  // The rise that closes the last period of a group; n wraps to 0 here.
  assign done    = enable & (state == MEASURE) & rise & (n == N_LAST);
  assign accept  = res.result_valid & res.result_ready;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = active;
    case (state)
      IDLE:    if (enable) state_n = ARM;
      ARM: begin
        if (!enable)   state_n = IDLE;
        else if (rise) state_n = MEASURE;
      end
      MEASURE: begin
        if (!enable)     state_n = IDLE;
        else if (to_hit) state_n = ARM;
      end
      default: state_n = IDLE;
    endcase
  end

  // ------------------------------------------------- counters/accumulators
  always_ff @(posedge clock) begin
    if (reset) begin
      timeout  <= 1'b0;
      wait_cnt <= '0;
      per_cnt  <= '0;
      hi_cnt   <= '0;
      per_acc  <= '0;
      hi_acc   <= '0;
      n        <= '0;
    end else begin
      timeout <= to_hit;
      if (!enable || state == IDLE || to_hit) begin
        // Leaving the measurement (or never in it): drop all partial data.
        wait_cnt <= '0;
        per_cnt  <= '0;
        hi_cnt   <= '0;
        per_acc  <= '0;
        hi_acc   <= '0;
        n        <= '0;
      end else if (rise) begin
        // The edge that ends one period starts the next: counts restart at
        // 1 because this edge is already the first clock of the new period.
        wait_cnt <= '0;
        per_cnt  <= CNT_ONE;
        hi_cnt   <= CNT_ONE;
        if (state == MEASURE) begin
          n       <= n + AVG_ONE;
          per_acc <= done ? '0 : per_new;
          hi_acc  <= done ? '0 : hi_new;
        end
      end else begin
        wait_cnt <= wait_cnt + CNT_ONE;
        if (state == MEASURE) begin
          per_cnt <= per_cnt + CNT_ONE;
          hi_cnt  <= hi_cnt + CNT_W'(ref_s);
        end
      end
    end
  end

  // ------------------------------------------------------ result handshake
  always_ff @(posedge clock) begin
    if (reset) begin
      res.result_valid <= 1'b0;
      res.period_sum   <= '0;
      res.high_sum     <= '0;
      res.overrun      <= 1'b0;
    end else if (done) begin
      // A load always wins; only an unaccepted result being replaced counts
      // as an overrun. A load coinciding with an accept leaves overrun as is.
      res.result_valid <= 1'b1;
      res.period_sum   <= per_new;
      res.high_sum     <= hi_new;
      if (res.result_valid && !res.result_ready) res.overrun <= 1'b1;
    end else if (accept) begin
      res.result_valid <= 1'b0;
      res.overrun      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_avk_period_meter.sv
module tb_avk_period_meter;

  localparam int CNT_W    = 24;
  localparam int AVG_LOG2 = 2;
  localparam int TO       = 5000;
  localparam int SUM_W    = CNT_W + AVG_LOG2;
  localparam int NAVG     = 1 << AVG_LOG2;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic en    = 1'b0;
  logic refin = 1'b0;
  logic timeout, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  logic [SUM_W-1:0] got_p[$], got_h[$], exp_p[$], exp_h[$];
  int got_c[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  avk_period_meter_if #(.W(SUM_W)) res_if ();

  avk_period_meter #(.CNT_W(CNT_W), .AVG_LOG2(AVG_LOG2), .TIMEOUT(TO)) dut (
    .clock     (clk),
    .reset     (rst),
    .enable    (en),
    .reference (refin),
    .timeout   (timeout),
    .busy      (busy),
    .res       (res_if)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Square wave: each entry is one period (clocks) with its high phase.
  // ack_idx selects the period on whose synced rise a 1-cycle ready pulse
  // is placed (rise is acted on 3 edges after the line changes).
  task automatic drive_waves(input int per_q[$], input int hi_q[$], input int ack_idx);
    foreach (per_q[i]) begin
      refin = 1'b1;
      if (i == ack_idx) begin
        tick(); tick();
        res_if.result_ready = 1'b1;
        tick();
        res_if.result_ready = 1'b0;
        repeat (hi_q[i] - 3) tick();
      end else begin
        repeat (hi_q[i]) tick();
      end
      refin = 1'b0;
      repeat (per_q[i] - hi_q[i]) tick();
    end
  endtask

  task automatic monitor(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      tick();
      if (res_if.result_valid && res_if.result_ready) begin
        got_p.push_back(res_if.period_sum);
        got_h.push_back(res_if.high_sum);
        got_c.push_back(cyc);
      end
    end
  endtask

  task automatic run_stream(input int per_q[$], input int hi_q[$], input int ack_idx);
    int total;
    total = 0;
    foreach (per_q[i]) total += per_q[i];
    got_p.delete(); got_h.delete(); got_c.delete();
    start_cyc = cyc;
    fork
      drive_waves(per_q, hi_q, ack_idx);
      monitor(total + 20);
    join
  endtask

  // Reference model: the first rise after arming opens period 0; every
  // NAVG complete periods form one result, reported on the rise closing them.
  task automatic build_expected(input int per_q[$], input int hi_q[$]);
    int sp, sh;
    exp_p.delete(); exp_h.delete();
    for (int k = 0; NAVG * k + NAVG < per_q.size(); k++) begin
      sp = 0; sh = 0;
      for (int j = 0; j < NAVG; j++) begin
        sp += per_q[NAVG * k + j];
        sh += hi_q[NAVG * k + j];
      end
      exp_p.push_back(SUM_W'(sp));
      exp_h.push_back(SUM_W'(sh));
    end
  endtask

  task automatic test_reset();
    logic seen_busy, seen_valid;
    rst = 1'b1; en = 1'b1; res_if.result_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin refin = ~refin; tick(); end
    checks++; if (res_if.result_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", res_if.result_valid); end
    checks++; if (res_if.overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %0b want 0", res_if.overrun); end
    checks++; if (res_if.period_sum !== '0) begin errors++; $display("FAIL rst_period: got %0d want 0", res_if.period_sum); end
    checks++; if (res_if.high_sum !== '0) begin errors++; $display("FAIL rst_high: got %0d want 0", res_if.high_sum); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %0b want 0", timeout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", busy); end
    rst = 1'b0; en = 1'b0;
    seen_busy = 1'b0; seen_valid = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (i % 7 == 0) refin = ~refin;
      tick();
      if (busy !== 1'b0) seen_busy = 1'b1;
      if (res_if.result_valid !== 1'b0) seen_valid = 1'b1;
    end
    refin = 1'b0;
    checks++; if (seen_busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b want 0", seen_busy); end
    checks++; if (seen_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %0b want 0", seen_valid); end
  endtask

  task automatic test_steady();
    int per_q[$], hi_q[$];
    res_if.result_ready = 1'b1; en = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 3 * NAVG + 1; i++) begin per_q.push_back(1000); hi_q.push_back(400); end
    build_expected(per_q, hi_q);
    run_stream(per_q, hi_q, -1);
    checks++; if (got_p.size() !== exp_p.size()) begin errors++; $display("FAIL steady_count: got %0d want %0d", got_p.size(), exp_p.size()); end
    for (int i = 0; i < got_p.size() && i < exp_p.size(); i++) begin
      checks++; if (got_p[i] !== exp_p[i]) begin errors++; $display("FAIL steady_period[%0d]: got %0d want %0d", i, got_p[i], exp_p[i]); end
      checks++; if (got_h[i] !== exp_h[i]) begin errors++; $display("FAIL steady_high[%0d]: got %0d want %0d", i, got_h[i], exp_h[i]); end
      if (i == 0) begin
        checks++; if (got_c[0] - start_cyc !== NAVG * 1000 + 3) begin errors++; $display("FAIL steady_latency: got %0d want %0d", got_c[0] - start_cyc, NAVG * 1000 + 3); end
      end else begin
        checks++; if (got_c[i] - got_c[i-1] !== NAVG * 1000) begin errors++; $display("FAIL steady_spacing[%0d]: got %0d want %0d", i, got_c[i] - got_c[i-1], NAVG * 1000); end
      end
    end
    en = 1'b0; repeat (2) tick();
  endtask

  task automatic test_random();
    int per_q[$], hi_q[$];
    int p;
    res_if.result_ready = 1'b1; en = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 3 * NAVG + 1; i++) begin
      p = int'($urandom_range(300, 8));
      per_q.push_back(p);
      hi_q.push_back(int'($urandom_range(p - 1, 1)));
    end
    build_expected(per_q, hi_q);
    run_stream(per_q, hi_q, -1);
    checks++; if (got_p.size() !== exp_p.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", got_p.size(), exp_p.size()); end
    for (int i = 0; i < got_p.size() && i < exp_p.size(); i++) begin
      checks++; if (got_p[i] !== exp_p[i]) begin errors++; $display("FAIL rand_period[%0d]: got %0d want %0d", i, got_p[i], exp_p[i]); end
      checks++; if (got_h[i] !== exp_h[i]) begin errors++; $display("FAIL rand_high[%0d]: got %0d want %0d", i, got_h[i], exp_h[i]); end
    end
    en = 1'b0; repeat (2) tick();
  endtask

  task automatic test_timeout();
    int per_q[$], hi_q[$];
    int t_seen, pulses, t_exp;
    res_if.result_ready = 1'b0; en = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < NAVG + 1; i++) begin per_q.push_back(500); hi_q.push_back(200); end
    run_stream(per_q, hi_q, -1);
    // Line now stuck low after the rise that delivered the result.
    t_exp = start_cyc + NAVG * 500 + 3 + TO;
    t_seen = -1; pulses = 0;
    for (int c = 0; c < 5100; c++) begin
      tick();
      if (timeout === 1'b1) begin
        pulses++;
        if (t_seen < 0) t_seen = cyc;
      end
    end
    checks++; if (t_seen !== t_exp) begin errors++; $display("FAIL to_time: got %0d want %0d", t_seen, t_exp); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL to_pulses: got %0d want 1", pulses); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_busy: got %0b want 1", busy); end
    checks++; if (res_if.result_valid !== 1'b1) begin errors++; $display("FAIL to_valid: got %0b want 1", res_if.result_valid); end
    checks++; if (res_if.period_sum !== SUM_W'(NAVG * 500)) begin errors++; $display("FAIL to_period: got %0d want %0d", res_if.period_sum, NAVG * 500); end
    checks++; if (res_if.high_sum !== SUM_W'(NAVG * 200)) begin errors++; $display("FAIL to_high: got %0d want %0d", res_if.high_sum, NAVG * 200); end
    res_if.result_ready = 1'b1; tick(); res_if.result_ready = 1'b0;
    en = 1'b0; repeat (2) tick();
  endtask

  task automatic test_handshake();
    int per_q[$], hi_q[$];
    res_if.result_ready = 1'b0; en = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < NAVG; i++) begin per_q.push_back(300); hi_q.push_back(100); end
    for (int i = 0; i < NAVG; i++) begin per_q.push_back(200); hi_q.push_back(150); end
    per_q.push_back(100); hi_q.push_back(50);
    build_expected(per_q, hi_q);
    run_stream(per_q, hi_q, -1);
    checks++; if (res_if.result_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %0b want 1", res_if.result_valid); end
    checks++; if (res_if.overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %0b want 1", res_if.overrun); end
    checks++; if (res_if.period_sum !== exp_p[1]) begin errors++; $display("FAIL ovr_period: got %0d want %0d", res_if.period_sum, exp_p[1]); end
    checks++; if (res_if.high_sum !== exp_h[1]) begin errors++; $display("FAIL ovr_high: got %0d want %0d", res_if.high_sum, exp_h[1]); end
    res_if.result_ready = 1'b1; tick(); res_if.result_ready = 1'b0;
    checks++; if (res_if.result_valid !== 1'b0) begin errors++; $display("FAIL acc_valid: got %0b want 0", res_if.result_valid); end
    checks++; if (res_if.overrun !== 1'b0) begin errors++; $display("FAIL acc_overrun: got %0b want 0", res_if.overrun); end
    en = 1'b0; repeat (2) tick();
    // Accept of the first result lands on the cycle the second one loads.
    en = 1'b1; repeat (4) tick();
    per_q.delete(); hi_q.delete();
    for (int i = 0; i < NAVG + 1; i++) begin per_q.push_back(120); hi_q.push_back(60); end
    for (int i = 0; i < NAVG - 1; i++) begin per_q.push_back(90); hi_q.push_back(30); end
    per_q.push_back(160); hi_q.push_back(40);
    build_expected(per_q, hi_q);
    run_stream(per_q, hi_q, 2 * NAVG);
    checks++; if (res_if.result_valid !== 1'b1) begin errors++; $display("FAIL coin_valid: got %0b want 1", res_if.result_valid); end
    checks++; if (res_if.overrun !== 1'b0) begin errors++; $display("FAIL coin_overrun: got %0b want 0", res_if.overrun); end
    checks++; if (res_if.period_sum !== exp_p[1]) begin errors++; $display("FAIL coin_period: got %0d want %0d", res_if.period_sum, exp_p[1]); end
    checks++; if (res_if.high_sum !== exp_h[1]) begin errors++; $display("FAIL coin_high: got %0d want %0d", res_if.high_sum, exp_h[1]); end
    res_if.result_ready = 1'b1; tick(); res_if.result_ready = 1'b0;
    checks++; if (res_if.result_valid !== 1'b0) begin errors++; $display("FAIL coin_accept: got %0b want 0", res_if.result_valid); end
    en = 1'b0; repeat (2) tick();
  endtask

  task automatic test_abort();
    int per_q[$], hi_q[$];
    res_if.result_ready = 1'b1; en = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 3; i++) begin per_q.push_back(700); hi_q.push_back(300); end
    run_stream(per_q, hi_q, -1);
    checks++; if (got_p.size() !== 0) begin errors++; $display("FAIL abort_early: got %0d results want 0", got_p.size()); end
    en = 1'b0; repeat (10) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b want 0", busy); end
    en = 1'b1; repeat (4) tick();
    per_q = '{250, 350, 450, 150, 300};
    hi_q  = '{50, 100, 200, 75, 120};
    build_expected(per_q, hi_q);
    run_stream(per_q, hi_q, -1);
    checks++; if (got_p.size() !== exp_p.size()) begin errors++; $display("FAIL abort_count: got %0d want %0d", got_p.size(), exp_p.size()); end
    if (got_p.size() > 0 && exp_p.size() > 0) begin
      checks++; if (got_p[0] !== exp_p[0]) begin errors++; $display("FAIL abort_period: got %0d want %0d", got_p[0], exp_p[0]); end
      checks++; if (got_h[0] !== exp_h[0]) begin errors++; $display("FAIL abort_high: got %0d want %0d", got_h[0], exp_h[0]); end
    end
    en = 1'b0; repeat (2) tick();
  endtask

  task automatic test_reset_measure();
    int per_q[$], hi_q[$];
    res_if.result_ready = 1'b0; en = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < NAVG + 1; i++) begin per_q.push_back(100); hi_q.push_back(30); end
    run_stream(per_q, hi_q, -1);
    checks++; if (res_if.result_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid: got %0b want 1", res_if.result_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_pre_busy: got %0b want 1", busy); end
    rst = 1'b1; tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %0b want 0", busy); end
    checks++; if (res_if.result_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %0b want 0", res_if.result_valid); end
    checks++; if (res_if.period_sum !== '0) begin errors++; $display("FAIL rm_period: got %0d want 0", res_if.period_sum); end
    checks++; if (res_if.high_sum !== '0) begin errors++; $display("FAIL rm_high: got %0d want 0", res_if.high_sum); end
    checks++; if (res_if.overrun !== 1'b0) begin errors++; $display("FAIL rm_overrun: got %0b want 0", res_if.overrun); end
    rst = 1'b0; en = 1'b0; tick();
  endtask

  initial begin
    res_if.result_ready = 1'b0;
    test_reset();
    test_steady();
    test_random();
    test_timeout();
    test_handshake();
    test_abort();
    test_reset_measure();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
